buffer_pool_reader: RTL and testbench
=====================================

BUFFER_POOL_READER -- requirements
Module: buffer_pool_reader

Interface
REQ-001 SHALL have parameters: X_MAC, default 4, MACs per mesh port; X_MESH, default 16, mesh ports; ADDR_LEN, default 13, bank address width; DATA_LEN, default 32, bank word width.
REQ-002 SHALL have derived parameters: BUFFER_NUM = X_MAC*X_MESH; DATAWIDTH = BUFFER_NUM*DATA_LEN; ADDRWIDTH = BUFFER_NUM*ADDR_LEN; RD_LAT = 2 (bank read latency); FIFO_DEPTH = 4.
REQ-003 SHALL use one clock, clk, and an asynchronous active-low reset, rst_n; ports in this order: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-004 SHALL have start input 1 (request pulse), base_addr input ADDR_LEN (first word address) and length input ADDR_LEN+1 (word count).
REQ-005 SHALL have busy output 1 and done output 1 (one-cycle completion pulse).
REQ-006 SHALL have addrb output ADDRWIDTH (bank read addresses, port B) and doutb input DATAWIDTH (bank read data).
REQ-007 SHALL have m_valid output 1, m_ready input 1, m_data output DATAWIDTH and m_last output 1 (output stream).

Function
REQ-008 SHALL implement states IDLE, READ, DRAIN and DONE.
REQ-009 SHALL, in IDLE with start=1 and length>0, latch base_addr and length, assert busy and enter READ.
REQ-010 SHALL, in IDLE with start=1 and length=0, go to DONE directly and emit no beats.
REQ-011 SHALL ignore start while busy.
REQ-012 SHALL drive the same address on all BUFFER_NUM addrb slices (broadcast).
REQ-013 SHALL, in READ, issue one read per cycle only when in-flight reads + FIFO occupancy < FIFO_DEPTH (credit rule); addrb then advances by 1.
REQ-014 SHALL wrap addresses modulo 2^ADDR_LEN; 2^ADDR_LEN-1 wraps to 0.
REQ-015 SHALL hold addrb at its last value when not issuing.
REQ-016 SHALL track issued reads in an RD_LAT-deep valid shift register and push doutb into the FIFO exactly RD_LAT cycles after issue; the FIFO shall never overflow.
REQ-017 SHALL enter DRAIN after the last read is issued.
REQ-018 SHALL go from DRAIN to DONE when no reads are in flight, the FIFO is empty and the final beat has handshaken.
REQ-019 SHALL, in DONE, pulse done for one cycle, drop busy and return to IDLE.
REQ-020 SHALL present the FIFO head as first-word fall-through; a beat transfers when m_valid=1 and m_ready=1.
REQ-021 SHALL hold m_data and m_last stable while m_valid=1 and m_ready=0.
REQ-022 SHALL assert m_last only on beat number length.
REQ-023 SHALL sustain 1 beat/cycle with m_ready held high.
REQ-024 SHALL make the first m_valid high 4 cycles after the start-accept edge (issue +1, RD_LAT +2, FIFO write +1).
REQ-025 SHALL allow a FIFO push and pop in the same cycle with occupancy unchanged.

Reset
REQ-026 SHALL, with rst_n=0 asynchronously, set state=IDLE, busy=0, done=0, m_valid=0, m_last=0, addrb=0, and clear FIFO, credits and the valid shift register.
REQ-027 SHALL, on reset mid-transfer, discard in-flight reads; returning bank data shall not be pushed.
REQ-028 SHALL leave m_data as don't-care under reset.

Configuration
REQ-029 SHALL, with macro BUFFER_POOL_READER_STALL_CNT_EN defined, add output stall_cnt, 16 bits: clears on start accept, increments each cycle m_valid=1 and m_ready=0, saturates at 16'hFFFF, resets to 0.
REQ-030 SHALL, without BUFFER_POOL_READER_STALL_CNT_EN, omit the stall_cnt port and its logic entirely.

Verification
REQ-031 Bench SHALL cover: base_addr=0x010, length=8, m_ready=1 -> addresses 0x010..0x017 on every slice, 8 beats on consecutive cycles, first m_valid 4 cycles after start, m_last on beat 8, done 1 cycle later.
REQ-032 Bench SHALL cover: base_addr=0x1FFE (ADDR_LEN=13), length=4 -> reads 0x1FFE, 0x1FFF, 0x0000, 0x0001.
REQ-033 Bench SHALL cover: length=16, m_ready=0 for 10 cycles then 1 -> issue stops at 4 outstanding, no data lost or reordered, all 16 beats in order; stall_cnt=10 when macro defined.
REQ-034 Bench SHALL cover: length=0 -> done pulse, zero beats, busy high at most 1 cycle.
REQ-035 Bench SHALL cover: second start during busy -> ignored; rst_n low on beat 3 of 8 -> all outputs at reset values; new start after release -> clean full transfer.

Source files
------------

// File: rtl/buffer_pool_reader.sv
// Buffer pool reader: streams a run of bank words through a credit-limited FWFT FIFO.
// Optional stall counter port is enabled by defining BUFFER_POOL_READER_STALL_CNT_EN.

// bpr_fifo: generic first-word-fall-through FIFO, DEPTH must be a power of two.
// Latency: 1 cycle from push to head_vld.
// Backpressure: none internally; the owner guarantees no push when full.
module bpr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_vld,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop_rdy,
    output logic [WIDTH-1:0]       head_dat,
    output logic                   head_vld,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop;

    assign head_vld = (count != '0);
    assign head_dat = mem[rd_ptr];
    assign pop      = pop_rdy && head_vld;

    // Storage carries no reset; head_dat is only meaningful while head_vld is set.
    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + AW'(1);
            if (pop)      rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push_vld} - {{AW{1'b0}}, pop};
        end
    end
endmodule

// buffer_pool_reader: reads length words from base_addr, broadcasting the address to all slices.
// Latency: first m_valid 4 cycles after start accept, then 1 beat/cycle.
// Backpressure: m_ready low stops issue once in-flight reads plus FIFO occupancy reach FIFO_DEPTH.
module buffer_pool_reader #(
    parameter int X_MAC    = 4,
    parameter int X_MESH   = 16,
    parameter int ADDR_LEN = 13,
    parameter int DATA_LEN = 32,
    localparam int BUFFER_NUM = X_MAC * X_MESH,
    localparam int DATAWIDTH  = BUFFER_NUM * DATA_LEN,
    localparam int ADDRWIDTH  = BUFFER_NUM * ADDR_LEN,
    localparam int RD_LAT     = 2,
    localparam int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_LEN-1:0]  base_addr,
    input  logic [ADDR_LEN:0]    length,
    output logic                 busy,
    output logic                 done,
    output logic [ADDRWIDTH-1:0] addrb,
    input  logic [DATAWIDTH-1:0] doutb,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATAWIDTH-1:0] m_data,
    output logic                 m_last
`ifdef BUFFER_POOL_READER_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [ADDR_LEN-1:0]       rd_addr;
    logic [ADDR_LEN-1:0]       addr_q;
    logic [ADDR_LEN:0]         rd_left;
    logic [ADDR_LEN:0]         out_left;
    logic                      addr_vld;
    logic [RD_LAT-1:0]         rd_sr;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
    logic [CW-1:0]             inflight;
    logic                      accept;
    logic                      issue;
    logic                      credit_ok;
    logic                      pop;

    assign accept = (state == IDLE) && start;
    assign pop    = m_valid && m_ready;
    assign addrb  = {BUFFER_NUM{addr_q}};
    assign m_last = m_valid && (out_left == (ADDR_LEN+1)'(1));

    // A read counts as in flight from address launch until its data lands in the FIFO.
    always_comb begin
        inflight = CW'(addr_vld);
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(rd_sr[i]);
    end

    // A beat leaving this cycle frees its slot, which keeps the stream at one beat per cycle.
    assign credit_ok = (inflight + CW'(fifo_cnt)) < (CW'(FIFO_DEPTH) + CW'(pop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (length == '0) ? DONE : READ;
            end
            READ: begin
                busy  = 1'b1;
                issue = credit_ok;
                if (credit_ok && rd_left == (ADDR_LEN+1)'(1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && m_last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr  <= '0;
            addr_q   <= '0;
            addr_vld <= 1'b0;
            rd_sr    <= '0;
            rd_left  <= '0;
            out_left <= '0;
        end else begin
            addr_vld <= issue;
            rd_sr    <= {rd_sr[RD_LAT-2:0], addr_vld};
            if (accept) begin
                rd_addr  <= base_addr;
                rd_left  <= length;
                out_left <= length;
            end
            if (issue) begin
                addr_q  <= rd_addr;
                rd_addr <= rd_addr + ADDR_LEN'(1);
                rd_left <= rd_left - (ADDR_LEN+1)'(1);
            end
            if (pop) out_left <= out_left - (ADDR_LEN+1)'(1);
        end
    end

    bpr_fifo #(
        .WIDTH (DATAWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (rd_sr[RD_LAT-1]),
        .push_dat (doutb),
        .pop_rdy  (m_ready),
        .head_dat (m_data),
        .head_vld (m_valid),
        .count    (fifo_cnt)
    );

`ifdef BUFFER_POOL_READER_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                          stall_cnt <= '0;
        else if (accept)                                     stall_cnt <= '0;
        else if (m_valid && !m_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_buffer_pool_reader.sv
// Bench for buffer_pool_reader: two-stage bank model, queue-based beat/address model, directed tests.
module tb_buffer_pool_reader;
    localparam int X_MAC    = 4;
    localparam int X_MESH   = 16;
    localparam int ADDR_LEN = 13;
    localparam int DATA_LEN = 32;
    localparam int BN       = X_MAC * X_MESH;
    localparam int DW       = BN * DATA_LEN;
    localparam int AWD      = BN * ADDR_LEN;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                start = 1'b0;
    logic                m_ready = 1'b0;
    logic [ADDR_LEN-1:0] base_addr = '0;
    logic [ADDR_LEN:0]   length = '0;
    logic                busy, done, m_valid, m_last;
    logic [AWD-1:0]      addrb;
    logic [DW-1:0]       doutb, m_data, bank_s1;
`ifdef BUFFER_POOL_READER_STALL_CNT_EN
    logic [15:0]         stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [DW:0]         exp_q[$];
    logic [ADDR_LEN-1:0] exp_a[$];
    logic [ADDR_LEN-1:0] issued_log[$];
    logic [DW-1:0]       got_q[$];

    int ncyc = 0, n_issued = 0, n_popped = 0, max_out = 0, beats = 0;
    int busy_cycles = 0, done_cnt = 0;
    int t_busy = -1, t_valid = -1, t_done = -1, t_last = -1;
    bit zero_len = 1'b0;
    logic [ADDR_LEN-1:0] prev_addr = '0;
    logic stall_prev = 1'b0, last_hs_prev = 1'b0, busy_prev = 1'b0, valid_prev = 1'b0, held_last = 1'b0;
    logic [DW-1:0] held_data;

    always #5 clk = ~clk;

    buffer_pool_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .addrb     (addrb),
        .doutb     (doutb),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
`ifdef BUFFER_POOL_READER_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    function automatic logic [DATA_LEN-1:0] word(input int slice, input logic [ADDR_LEN-1:0] a);
        return {8'(slice), 11'h2A5, a};
    endfunction

    // Bank: each slice reads its own address, data appears two cycles after the address.
    always @(posedge clk) begin
        for (int i = 0; i < BN; i++) bank_s1[i*DATA_LEN +: DATA_LEN] <= word(i, addrb[i*ADDR_LEN +: ADDR_LEN]);
        doutb <= bank_s1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_model(input logic [ADDR_LEN-1:0] b, input int len);
        logic [DW:0] beat;
        logic [ADDR_LEN-1:0] a;
        for (int k = 0; k < len; k++) begin
            a = b + ADDR_LEN'(k);
            exp_a.push_back(a);
            for (int i = 0; i < BN; i++) beat[i*DATA_LEN +: DATA_LEN] = word(i, a);
            beat[DW] = (k == len - 1);
            exp_q.push_back(beat);
        end
    endtask

    task automatic clr_stats();
        n_issued = 0; n_popped = 0; max_out = 0; beats = 0; busy_cycles = 0; done_cnt = 0;
        t_busy = -1; t_valid = -1; t_done = -1; t_last = -1;
        issued_log.delete();
        got_q.delete();
    endtask

    task automatic do_start(input logic [ADDR_LEN-1:0] b, input int len, input bit model);
        @(posedge clk); #1;
        base_addr = b;
        length    = (ADDR_LEN+1)'(len);
        start     = 1'b1;
        if (model) load_model(b, len);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_cnt == 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_done_seen"}, done_cnt != 0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Compare process: everything is sampled on the falling edge.
    always @(negedge clk) begin
        logic [DW:0] e;
        logic [ADDR_LEN-1:0] a0;
        logic bc_ok;
        ncyc++;
        a0 = addrb[ADDR_LEN-1:0];
        if (!rst_n) begin
            prev_addr = a0; stall_prev = 0; last_hs_prev = 0; busy_prev = 0; valid_prev = 0;
        end else begin
            bc_ok = 1'b1;
            for (int i = 1; i < BN; i++) if (addrb[i*ADDR_LEN +: ADDR_LEN] !== a0) bc_ok = 1'b0;
            chk("addr_broadcast", bc_ok, 1);
            if (a0 !== prev_addr) begin
                n_issued++;
                issued_log.push_back(a0);
                chk("issue_in_model", exp_a.size() != 0, 1);
                if (exp_a.size() != 0) chk("issue_addr", a0, exp_a.pop_front());
                prev_addr = a0;
            end
            if (n_issued - n_popped > max_out) max_out = n_issued - n_popped;
            if (stall_prev) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data === held_data, 1);
                chk("hold_last", m_last, held_last);
            end
            if (busy) busy_cycles++;
            if (busy && !busy_prev && t_busy < 0) t_busy = ncyc;
            if (m_valid && !valid_prev && t_valid < 0) t_valid = ncyc;
            if (done) begin
                done_cnt++;
                t_done = ncyc;
                chk("done_follows_last", last_hs_prev || zero_len, 1);
            end
            if (m_valid && m_ready) begin
                chk("beat_in_model", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (m_data !== e[DW-1:0]) begin
                        errors++;
                        $display("FAIL beat_data beat=%0d: got[63:0] %h expected[63:0] %h", beats + 1, m_data[63:0], e[63:0]);
                    end
                    chk("beat_last", m_last, e[DW]);
                end
                got_q.push_back(m_data);
                n_popped++;
                beats++;
                if (m_last) t_last = ncyc;
            end
            stall_prev   = m_valid && !m_ready;
            held_data    = m_data;
            held_last    = m_last;
            last_hs_prev = m_valid && m_ready && m_last;
            busy_prev    = busy;
            valid_prev   = m_valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] tmp;
        int n;
        int spurious;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_addrb_zero", addrb == '0, 1);
        @(posedge clk); #1 rst_n = 1'b1;

        // Streaming at full rate.
        clr_stats();
        m_ready = 1'b1;
        do_start(13'h010, 8, 1);
        wait_done("t1");
        chk("t1_beats", beats, 8);
        chk("t1_first_valid_lat", t_valid - t_busy, 4);
        chk("t1_consecutive", t_last - t_valid, 7);
        chk("t1_done_after_last", t_done - t_last, 1);
        chk("t1_done_pulses", done_cnt, 1);
        chk("t1_busy_dropped", busy, 0);
        tmp = got_q[0];
        chk("t1_beat1_slice0", tmp[31:0], 32'h0054A010);
        chk("t1_model_drained", exp_q.size(), 0);

        // Address wrap.
        clr_stats();
        do_start(13'h1FFE, 4, 1);
        wait_done("t2");
        chk("t2_issue_count", issued_log.size(), 4);
        if (issued_log.size() == 4) begin
            chk("t2_addr0", issued_log[0], 13'h1FFE);
            chk("t2_addr1", issued_log[1], 13'h1FFF);
            chk("t2_addr2", issued_log[2], 13'h0000);
            chk("t2_addr3", issued_log[3], 13'h0001);
        end
        chk("t2_beats", beats, 4);
        if (got_q.size() >= 3) begin
            tmp = got_q[2];
            chk("t2_beat3_slice5", tmp[191:160], 32'h0554A000);
        end

        // Backpressure: ten stalled cycles with data waiting.
        clr_stats();
        m_ready = 1'b0;
        do_start(13'h100, 16, 1);
        n = 0;
        while (!m_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t3_valid_seen", m_valid, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("t3_issued_in_stall", n_issued, 4);
        chk("t3_max_outstanding", max_out, 4);
        m_ready = 1'b1;
        wait_done("t3");
        chk("t3_beats", beats, 16);
        chk("t3_model_drained", exp_q.size(), 0);
`ifdef BUFFER_POOL_READER_STALL_CNT_EN
        chk("t3_stall_cnt", stall_cnt, 16'd10);
`endif

        // Zero length.
        clr_stats();
        zero_len = 1'b1;
        do_start(13'h055, 0, 1);
        repeat (4) @(posedge clk);
        #1;
        zero_len = 1'b0;
        chk("t4_done_pulses", done_cnt, 1);
        chk("t4_beats", beats, 0);
        chk("t4_busy_short", busy_cycles <= 1, 1);
        chk("t4_no_issue", n_issued, 0);

        // Ignored restart, then reset mid-transfer.
        clr_stats();
        do_start(13'h200, 8, 1);
        do_start(13'h300, 3, 0);
        n = 0;
        while (beats < 3 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5_beat3_seen", beats >= 3, 1);
        rst_n = 1'b0;
        exp_q.delete();
        exp_a.delete();
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_m_valid", m_valid, 0);
        chk("t5_rst_m_last", m_last, 0);
        chk("t5_rst_addrb_zero", addrb == '0, 1);
        chk("t5_no_done", done_cnt, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        spurious = 0;
        repeat (6) begin
            @(negedge clk);
            if (m_valid !== 1'b0) spurious++;
        end
        chk("t5_no_stale_push", spurious, 0);
        clr_stats();
        do_start(13'h040, 8, 1);
        wait_done("t5b");
        chk("t5b_beats", beats, 8);
        chk("t5b_done_pulses", done_cnt, 1);
        chk("t5b_model_drained", exp_q.size(), 0);
`ifdef BUFFER_POOL_READER_STALL_CNT_EN
        chk("t5b_stall_cnt_cleared", stall_cnt, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
